// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width constants and stage-count derivation for the pipelined adder
package adder_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_SLICE_W = 4;

  function automatic int calc_nstage(input int width, input int slice_w);
    return (slice_w < 1) ? 1 : width / slice_w;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit adder slice with carry in and carry out
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_s,
  output logic         o_c
);

  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_c};

endmodule

// File: rtl/adder_pipelined.sv
// rtl/adder_pipelined.sv - carry-pipelined adder/subtractor, one SLICE_W slice resolved per stage
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SLICE_W = DEFAULT_SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSTAGE = calc_nstage(WIDTH, SLICE_W);

  if ((SLICE_W < 1) || ((WIDTH % SLICE_W) != 0)) begin : g_param_check
    $error("adder_pipelined: WIDTH must be a positive multiple of SLICE_W");
  end

  logic w_advance;

  // The stall is global: a held result freezes every stage, bubbles included.
  assign w_advance = !(out_valid && !out_ready);
  assign in_ready  = w_advance || !rst_n;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = k * SLICE_W;
    localparam int IW = WIDTH - LO;

    logic [IW-1:0]         w_a_in;
    logic [IW-1:0]         w_b_in;
    logic                  w_c_in;
    logic                  w_v_in;
    logic [SLICE_W-1:0]    w_slice_s;
    logic                  w_slice_c;
    logic [LO+SLICE_W-1:0] r_s;
    logic                  r_c;
    logic                  r_v;

    if (k == 0) begin : g_head
      assign w_a_in = a;
      assign w_b_in = sub ? ~b : b;
      assign w_c_in = sub ? 1'b1 : cin;
      assign w_v_in = in_valid;

      always_ff @(posedge clk) begin
        if (!rst_n)         r_s <= '0;
        else if (w_advance) r_s <= w_slice_s;
      end
    end else begin : g_body
      assign w_a_in = g_stage[k-1].g_fwd.r_a;
      assign w_b_in = g_stage[k-1].g_fwd.r_b;
      assign w_c_in = g_stage[k-1].r_c;
      assign w_v_in = g_stage[k-1].r_v;

      always_ff @(posedge clk) begin
        if (!rst_n)         r_s <= '0;
        else if (w_advance) r_s <= {w_slice_s, g_stage[k-1].r_s};
      end
    end

    adder_slice #(.W(SLICE_W)) u_slice (
      .i_a (w_a_in[SLICE_W-1:0]),
      .i_b (w_b_in[SLICE_W-1:0]),
      .i_c (w_c_in),
      .o_s (w_slice_s),
      .o_c (w_slice_c)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
      end else if (w_advance) begin
        r_v <= w_v_in;
        r_c <= w_slice_c;
      end
    end

    // Only operand bits above this slice travel on; the top slice carries both MSBs.
    if (k < NSTAGE - 1) begin : g_fwd
      logic [IW-SLICE_W-1:0] r_a;
      logic [IW-SLICE_W-1:0] r_b;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_in[IW-1:SLICE_W];
          r_b <= w_b_in[IW-1:SLICE_W];
        end
      end
    end else begin : g_tail
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_advance) r_ovf <= (w_a_in[IW-1] == w_b_in[IW-1]) &&
                                     (w_slice_s[SLICE_W-1] != w_a_in[IW-1]);
      end
    end
  end

  assign out_valid = g_stage[NSTAGE-1].r_v;
  assign sum       = g_stage[NSTAGE-1].r_s;
  assign carry_out = g_stage[NSTAGE-1].r_c;
  assign overflow  = g_stage[NSTAGE-1].g_tail.r_ovf;

endmodule

// File: doc/adder_pipelined.md
ADDER_PIPELINED -- requirements
Module: adder_pipelined

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter SLICE_W, default 4: bits resolved per pipeline stage. WIDTH SHALL be a multiple of SLICE_W. NSTAGE = WIDTH/SLICE_W.
REQ-003 SHALL have one clock and a synchronous, active-low reset:
  clk  in  1  clock; all state updates on the rising edge.
  rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL have these handshake and data ports:
  in_valid  in  1  operand set presented.
  in_ready  out  1  block can accept this cycle.
  a  in  WIDTH  operand A.
  b  in  WIDTH  operand B.
  cin  in  1  carry-in; used only when sub=0.
  sub  in  1  0: a+b+cin; 1: a+~b+1 (a-b).
  out_valid  out  1  result valid.
  out_ready  in  1  consumer accepts the result.
  sum  out  WIDTH  result modulo 2^WIDTH.
  carry_out  out  1  carry from the MSB. For sub=1, 1 means no borrow.
  overflow  out  1  signed two's-complement overflow.

Function
REQ-005 A transaction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-006 The pipeline SHALL have NSTAGE register stages. Stage k SHALL resolve bits [k*SLICE_W +: SLICE_W] from:
  - the carry registered by stage k-1;
  - the skewed operand bits carried forward from earlier stages.
  Stage 0 SHALL use cin, or 1 when sub=1.
REQ-007 Latency SHALL be NSTAGE cycles: out_valid=1 for a transaction after the NSTAGE-th rising edge, counting the accept edge as the first, when there is no stall.
REQ-008 With no stall, throughput SHALL be one transaction per cycle.
REQ-009 The advance signal SHALL be !(out_valid && !out_ready). in_ready SHALL equal advance, derived combinationally.
REQ-010 When advance=0, every stage register and all outputs SHALL hold their values.
REQ-011 Bubbles SHALL NOT be compressed during a stall; the stall is global.
REQ-012 Each stage SHALL carry a valid bit. An invalid stage SHALL propagate its bubble; it SHALL NOT produce out_valid.
REQ-013 sum, carry_out and overflow SHALL be registered outputs, aligned to out_valid. All sum slices of one transaction SHALL appear in the same cycle.
REQ-014 overflow SHALL be 1 iff a[MSB] equals beff[MSB] and sum[MSB] differs from a[MSB], where beff = sub ? ~b : b.
REQ-015 Transactions SHALL leave in acceptance order, with no loss and no duplication.
REQ-016 While out_valid=1 and out_ready=0, sum, carry_out and overflow SHALL stay stable until the result is accepted.
REQ-017 For the boundary case NSTAGE=1 (SLICE_W=WIDTH), the block SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-018 When rst_n=0 at a rising edge:
  - all stage valid bits SHALL clear;
  - out_valid, sum, carry_out and overflow SHALL become 0;
  - in-flight transactions SHALL be discarded.
REQ-019 During reset, in_ready SHALL be 1. No transaction SHALL be accepted on an edge where rst_n=0.
REQ-020 Reset asserted mid-stream SHALL take effect at the next edge, regardless of out_ready.

Structure
REQ-021 A shared package adder_pkg SHALL hold:
  - the default WIDTH and SLICE_W constants;
  - the NSTAGE derivation.
  It SHALL hold no per-instance state.
REQ-022 A combinational sub-module adder_slice (SLICE_W-bit add with carry in and carry out) SHALL be instantiated once per stage via generate.
REQ-023 Parameter legality (WIDTH mod SLICE_W = 0, SLICE_W >= 1) SHALL be checked at elaboration.

Verification (WIDTH=16, SLICE_W=4 unless stated)
REQ-024 a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, carry_out=1, overflow=0, out_valid 4 cycles after accept.
REQ-025 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1, carry_out=1.
REQ-026 a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, carry_out=0, overflow=0.
REQ-027 Stream of 8 back-to-back random transactions, with out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall;
  - outputs hold during the stall;
  - all 8 results are correct, in order, each exactly once.
REQ-028 rst_n=0 for 1 cycle with 3 transactions in flight -> next cycle out_valid=0, sum=0; none of the 3 results ever emerges.
REQ-029 WIDTH=2, SLICE_W=1: exhaustive a, b, cin, sub, checked against a reference model ({carry_out,sum}=a+b+cin, or a-b), with overflow checked per REQ-014.
